seq_detector_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 13 +
 rtl/sat_counter.sv | 35 +++
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned W_DEF = 5;
  localparam int unsigned CNT_W_DEF = 8;
  localparam logic [31:0] PAT_RST_DEF = 32'b10101;

  // Fill counter must be able to hold the value w itself.
  function automatic int unsigned fill_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones once full.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: W-bit history compared against a loadable masked pattern,
// registered match pulse and saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned    W       = W_DEF,
  parameter int unsigned    CNT_W   = CNT_W_DEF,
  parameter logic [W-1:0]   PAT_RST = W'(PAT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [W-1:0]     pat_in,
  input  logic [W-1:0]     mask_in,
  input  logic             clr,
  output logic             z,
  output logic [W-1:0]     seq,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [W-1:0]     pattern
);

  localparam int unsigned FW = fill_width(W);
  localparam logic [FW-1:0] FILL_FULL = FW'(W);

  logic [W-1:0]  seq_q, seq_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          z_q, z_d;

  logic [W-1:0]  seq_next;
  logic [FW-1:0] fill_inc;
  logic          match;
  logic          hit_inc;

  always_comb begin
    seq_next = {seq_q[W-2:0], x};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    match    = x_valid && (((seq_next ^ pat_q) & mask_q) == '0) && (fill_inc == FILL_FULL);

    seq_d   = seq_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    z_d     = 1'b0;
    hit_inc = 1'b0;

    if (clr) begin
      seq_d  = '0;
      fill_d = '0;
    end else if (pat_load) begin
      // A bit arriving together with a new pattern is dropped.
      pat_d  = pat_in;
      mask_d = mask_in;
      seq_d  = '0;
      fill_d = '0;
    end else if (x_valid) begin
      seq_d   = seq_next;
      fill_d  = (match && !overlap) ? '0 : fill_inc;
      z_d     = match;
      hit_inc = match;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q  <= '0;
      pat_q  <= PAT_RST;
      mask_q <= '1;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(hit_inc),
    .cnt(hit_cnt)
  );

  assign z       = z_q;
  assign seq     = seq_q;
  assign pattern = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param, plus a CNT_W=2 saturation instance.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, x_valid, overlap, pat_load, clr;
  logic [4:0] pat_in, mask_in;
  logic       z;
  logic [4:0] seq, pattern;
  logic [7:0] hit_cnt;

  logic       d2_x, d2_valid, d2_clr;
  logic       d2_z;
  logic [4:0] d2_seq, d2_pattern;
  logic [1:0] d2_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.W(5), .CNT_W(8), .PAT_RST(5'b10101)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in), .clr(clr),
    .z(z), .seq(seq), .hit_cnt(hit_cnt), .pattern(pattern)
  );

  seq_detector_param #(.W(5), .CNT_W(2), .PAT_RST(5'b10101)) dut2 (
    .clk(clk), .rst(rst), .x(d2_x), .x_valid(d2_valid), .overlap(1'b1),
    .pat_load(1'b0), .pat_in(5'b00000), .mask_in(5'b11111), .clr(d2_clr),
    .z(d2_z), .seq(d2_seq), .hit_cnt(d2_cnt), .pattern(d2_pattern)
  );

  typedef struct {
    logic       v, x, ov, clr, ld;
    logic [4:0] pin, min;
    logic       ez;
    logic [7:0] ecnt;
    logic [4:0] eseq, epat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic xb, input logic ov, input logic c,
                     input logic ld, input logic [4:0] pin, input logic [4:0] min,
                     input logic ez, input logic [7:0] ecnt, input logic [4:0] eseq,
                     input logic [4:0] epat);
    vec_t e;
    e.v = v; e.x = xb; e.ov = ov; e.clr = c; e.ld = ld; e.pin = pin; e.min = min;
    e.ez = ez; e.ecnt = ecnt; e.eseq = eseq; e.epat = epat;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one main-DUT cycle on the falling edge; outputs are sampled 1ns after the rise.
  task automatic step(input logic v, input logic xb, input logic ov);
    @(negedge clk);
    x_valid = v; x = xb; overlap = ov; clr = 1'b0; pat_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic xb, input logic c);
    @(negedge clk);
    d2_valid = v; d2_x = xb; d2_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] p, m1, m0;
    logic [4:0] bits_a;
    logic [4:0] zexp;
    logic [12:0] sat_bits;
    logic [1:0]  sat_exp [13];
    p = 5'b10101; m1 = 5'b11111; m0 = 5'b00000;

    rst = 1'b0; x = 0; x_valid = 0; overlap = 1; pat_load = 0; clr = 0;
    pat_in = '0; mask_in = '0; d2_x = 0; d2_valid = 0; d2_clr = 0;

    // Overlapping stream 1010101: pulses after bits 5 and 7.
    add(1,1,1,0,0, m0,m0, 0,0,5'b00001,p);
    add(1,0,1,0,0, m0,m0, 0,0,5'b00010,p);
    add(1,1,1,0,0, m0,m0, 0,0,5'b00101,p);
    add(1,0,1,0,0, m0,m0, 0,0,5'b01010,p);
    add(1,1,1,0,0, m0,m0, 1,1,5'b10101,p);
    add(1,0,1,0,0, m0,m0, 0,1,5'b01010,p);
    add(1,1,1,0,0, m0,m0, 1,2,5'b10101,p);
    // clr wins over a valid bit.
    add(1,1,1,1,0, m0,m0, 0,0,5'b00000,p);
    // Non-overlapping: only the bit-5 pulse.
    add(1,1,0,0,0, m0,m0, 0,0,5'b00001,p);
    add(1,0,0,0,0, m0,m0, 0,0,5'b00010,p);
    add(1,1,0,0,0, m0,m0, 0,0,5'b00101,p);
    add(1,0,0,0,0, m0,m0, 0,0,5'b01010,p);
    add(1,1,0,0,0, m0,m0, 1,1,5'b10101,p);
    add(1,0,0,0,0, m0,m0, 0,1,5'b01010,p);
    add(1,1,0,0,0, m0,m0, 0,1,5'b10101,p);
    // Masked pattern 110xx; the bit on the load edge is dropped.
    add(1,1,1,0,1, 5'b11000,5'b11100, 0,1,5'b00000,5'b11000);
    add(1,1,1,0,0, m0,m0, 0,1,5'b00001,5'b11000);
    add(1,1,1,0,0, m0,m0, 0,1,5'b00011,5'b11000);
    add(1,0,1,0,0, m0,m0, 0,1,5'b00110,5'b11000);
    add(1,1,1,0,0, m0,m0, 0,1,5'b01101,5'b11000);
    add(1,1,1,0,0, m0,m0, 1,2,5'b11011,5'b11000);
    // Reload 10101, then stream with x_valid gaps.
    add(0,0,1,0,1, p,m1, 0,2,5'b00000,p);
    add(1,1,1,0,0, m0,m0, 0,2,5'b00001,p);
    add(0,0,1,0,0, m0,m0, 0,2,5'b00001,p);
    add(1,0,1,0,0, m0,m0, 0,2,5'b00010,p);
    add(0,1,1,0,0, m0,m0, 0,2,5'b00010,p);
    add(1,1,1,0,0, m0,m0, 0,2,5'b00101,p);
    add(1,0,1,0,0, m0,m0, 0,2,5'b01010,p);
    add(0,1,1,0,0, m0,m0, 0,2,5'b01010,p);
    add(1,1,1,0,0, m0,m0, 1,3,5'b10101,p);
    add(0,0,1,0,0, m0,m0, 0,3,5'b10101,p);
    // All-zero mask: every valid bit matches once full; overlap drop forces refill.
    add(0,0,1,0,1, m0,m0, 0,3,5'b00000,m0);
    add(1,1,1,0,0, m0,m0, 0,3,5'b00001,m0);
    add(1,1,1,0,0, m0,m0, 0,3,5'b00011,m0);
    add(1,0,1,0,0, m0,m0, 0,3,5'b00110,m0);
    add(1,1,1,0,0, m0,m0, 0,3,5'b01101,m0);
    add(1,0,1,0,0, m0,m0, 1,4,5'b11010,m0);
    add(1,1,1,0,0, m0,m0, 1,5,5'b10101,m0);
    add(1,0,0,0,0, m0,m0, 1,6,5'b01010,m0);
    add(1,0,0,0,0, m0,m0, 0,6,5'b10100,m0);

    #12;
    check("reset_z", {31'd0, z}, 32'd0);
    check("reset_seq", {27'd0, seq}, 32'd0);
    check("reset_cnt", {24'd0, hit_cnt}, 32'd0);
    check("reset_pattern", {27'd0, pattern}, {27'd0, p});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      x_valid = tbl[i].v; x = tbl[i].x; overlap = tbl[i].ov; clr = tbl[i].clr;
      pat_load = tbl[i].ld; pat_in = tbl[i].pin; mask_in = tbl[i].min;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_z", i), {31'd0, z}, {31'd0, tbl[i].ez});
      check($sformatf("vec%0d_cnt", i), {24'd0, hit_cnt}, {24'd0, tbl[i].ecnt});
      check($sformatf("vec%0d_seq", i), {27'd0, seq}, {27'd0, tbl[i].eseq});
      check($sformatf("vec%0d_pat", i), {27'd0, pattern}, {27'd0, tbl[i].epat});
    end

    // Mid-stream asynchronous reset restores pattern and full mask.
    step(1, 1, 1); step(1, 0, 1); step(1, 1, 1);
    @(negedge clk);
    x_valid = 0;
    rst = 1'b0;
    #1;
    check("async_rst_seq", {27'd0, seq}, 32'd0);
    check("async_rst_cnt", {24'd0, hit_cnt}, 32'd0);
    check("async_rst_pat", {27'd0, pattern}, {27'd0, p});
    check("async_rst_z", {31'd0, z}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1); check("post_rst_b1_z", {31'd0, z}, 32'd0);
    step(1, 1, 1); check("post_rst_b2_z", {31'd0, z}, 32'd0);
    bits_a = 5'b10101;
    zexp = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      step(1, bits_a[i], 1);
      check($sformatf("post_rst_seq_bit%0d_z", 4 - i), {31'd0, z}, {31'd0, zexp[i]});
    end
    check("post_rst_cnt", {24'd0, hit_cnt}, 32'd1);

    // CNT_W=2 instance: five overlapping matches saturate at 3.
    sat_bits = 13'b1010101010101;
    for (int i = 0; i < 13; i++) sat_exp[i] = 2'd0;
    sat_exp[4] = 2'd1; sat_exp[5] = 2'd1; sat_exp[6] = 2'd2; sat_exp[7] = 2'd2;
    for (int i = 8; i < 13; i++) sat_exp[i] = 2'd3;
    for (int i = 0; i < 13; i++) begin
      step2(1, sat_bits[12 - i], 0);
      check($sformatf("sat_bit%0d_cnt", i), {30'd0, d2_cnt}, {30'd0, sat_exp[i]});
    end
    check("sat_last_z", {31'd0, d2_z}, 32'd1);
    step2(0, 0, 1);
    check("sat_clr_cnt", {30'd0, d2_cnt}, 32'd0);
    check("sat_clr_seq", {27'd0, d2_seq}, 32'd0);
    check("sat_clr_z", {31'd0, d2_z}, 32'd0);
    check("sat_clr_pat", {27'd0, d2_pattern}, {27'd0, p});
    step2(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
